// File: rtl/ib_uart_tx_arb.sv
// Round-robin arbiter and framer between two byte sources and the UART transmitter.
// Status bytes go out behind PREFIX; meter bytes equal to PREFIX are sent doubled.
module ib_uart_tx_arb #(
   parameter logic [7:0] PREFIX = 8'h1B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] m_data,
   input  logic       m_valid,
   output logic       m_ack,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ack,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ack,
   output logic       s_err,
   output logic       busy
);

   localparam int unsigned DW = 8;

   typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

   state_t        state, state_nx;
   logic [DW-1:0] hold, hold_nx;
   logic [DW-1:0] tx_data_nx;
   logic          sel, sel_nx;            // 1 = status source
   logic          two, two_nx;
   logic          last_sel, last_sel_nx;  // 1 = status source
   logic          tx_valid_nx, m_ack_nx, s_ack_nx, s_err_nx;
   logic          grant_m, grant_s;

   // Under contention the source that was not served last wins
   assign grant_m = m_valid && (!s_valid || last_sel);
   assign grant_s = s_valid && (!m_valid || !last_sel);

   // Next-state and next-output logic
   always_comb begin
      state_nx    = state;
      hold_nx     = hold;
      sel_nx      = sel;
      two_nx      = two;
      last_sel_nx = last_sel;
      tx_data_nx  = tx_data;
      tx_valid_nx = 1'b0;
      m_ack_nx    = 1'b0;
      s_ack_nx    = 1'b0;
      s_err_nx    = s_err;

      case (state)
         IDLE: begin
            if (grant_m) begin
               hold_nx     = m_data;
               sel_nx      = 1'b0;
               last_sel_nx = 1'b0;
               two_nx      = (m_data == PREFIX);
               tx_data_nx  = m_data;
               tx_valid_nx = 1'b1;
               state_nx    = TX1;
            end else if (grant_s) begin
               hold_nx     = s_data;
               sel_nx      = 1'b1;
               last_sel_nx = 1'b1;
               if (s_data == PREFIX) begin
                  // Cannot be framed unambiguously: drop it but still acknowledge
                  s_err_nx = 1'b1;
                  s_ack_nx = 1'b1;
                  state_nx = DONE;
               end else begin
                  two_nx      = 1'b1;
                  tx_data_nx  = PREFIX;
                  tx_valid_nx = 1'b1;
                  state_nx    = TX1;
               end
            end
         end
         TX1: begin
            if (tx_ack) begin
               if (two) begin
                  tx_data_nx = hold;
                  state_nx   = GAP;
               end else begin
                  m_ack_nx = !sel;
                  s_ack_nx = sel;
                  state_nx = DONE;
               end
            end else begin
               tx_valid_nx = 1'b1;
            end
         end
         GAP: begin
            tx_valid_nx = 1'b1;
            state_nx    = TX2;
         end
         TX2: begin
            if (tx_ack) begin
               m_ack_nx = !sel;
               s_ack_nx = sel;
               state_nx = DONE;
            end else begin
               tx_valid_nx = 1'b1;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold     <= '0;
         sel      <= 1'b0;
         two      <= 1'b0;
         last_sel <= 1'b1;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         m_ack    <= 1'b0;
         s_ack    <= 1'b0;
         s_err    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         hold     <= hold_nx;
         sel      <= sel_nx;
         two      <= two_nx;
         last_sel <= last_sel_nx;
         tx_data  <= tx_data_nx;
         tx_valid <= tx_valid_nx;
         m_ack    <= m_ack_nx;
         s_ack    <= s_ack_nx;
         s_err    <= s_err_nx;
         busy     <= (state_nx != IDLE);
      end
   end

endmodule
